// File: rtl/sid_table_sched.sv
// Time-multiplexed access sequencer for the shared waveform-combination table.
// Each ce_1m restarts a pass that issues and captures one voice per slot.
module sid_table_sched #(
    parameter int NUM_VOICES  = 3,
    parameter int SLOT_CYCLES = 4,
    parameter int TABLE_LAT   = 2,
    parameter int ACC_W       = 12,
    parameter int OUT_W       = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce_1m,
    input  logic [NUM_VOICES*ACC_W-1:0] acc_ps,
    input  logic [NUM_VOICES*ACC_W-1:0] acc_t,
    output logic [ACC_W-1:0]            tbl_acc_ps,
    output logic [ACC_W-1:0]            tbl_acc_t,
    input  logic [OUT_W-1:0]            tbl_st_in,
    input  logic [OUT_W-1:0]            tbl_pt_in,
    input  logic [OUT_W-1:0]            tbl_ps_in,
    input  logic [OUT_W-1:0]            tbl_pst_in,
    output logic [NUM_VOICES*OUT_W-1:0] st_out,
    output logic [NUM_VOICES*OUT_W-1:0] pt_out,
    output logic [NUM_VOICES*OUT_W-1:0] ps_out,
    output logic [NUM_VOICES*OUT_W-1:0] pst_out,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun,
    input  logic                        overrun_clr
);

    localparam int END = NUM_VOICES * SLOT_CYCLES;
    localparam int CW  = $clog2(END + 1);
    localparam int SW  = $clog2(NUM_VOICES + 1);
    localparam int OW  = $clog2(SLOT_CYCLES);
    localparam int CAP = 1 + TABLE_LAT;

    generate
        if (TABLE_LAT + 2 > SLOT_CYCLES || NUM_VOICES < 1 || NUM_VOICES > 16) begin : g_bad
            $error("sid_table_sched: illegal NUM_VOICES/SLOT_CYCLES/TABLE_LAT");
        end
    endgenerate

    logic [CW-1:0]    cnt;
    logic [SW-1:0]    slot;
    logic [OW-1:0]    off;
    logic             active;
    logic             issue;
    logic             capture;
    logic             last;
    logic             pending;
    logic [ACC_W-1:0] sel_ps;
    logic [ACC_W-1:0] sel_t;

    assign active  = cnt < CW'(END);
    assign issue   = active && !ce_1m && off == OW'(1);
    assign capture = active && !ce_1m && off == OW'(CAP);
    assign last    = capture && slot == SW'(NUM_VOICES - 1);
    // A pass counts as pending from its restart until the last capture.
    assign pending = busy || cnt == '0;

    always_comb begin
        sel_ps = '0;
        sel_t  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (slot == SW'(v)) begin
                sel_ps = acc_ps[v*ACC_W +: ACC_W];
                sel_t  = acc_t[v*ACC_W +: ACC_W];
            end
        end
    end

    // cnt tracks the flat position; slot/off replace a divide by SLOT_CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= CW'(END);
            slot <= SW'(NUM_VOICES);
            off  <= '0;
        end else if (ce_1m) begin
            cnt  <= '0;
            slot <= '0;
            off  <= '0;
        end else if (active) begin
            cnt <= cnt + CW'(1);
            if (off == OW'(SLOT_CYCLES - 1)) begin
                off  <= '0;
                slot <= slot + SW'(1);
            end else begin
                off <= off + OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= last;
            if (!ce_1m) begin
                if (cnt == '0) begin
                    busy <= 1'b1;
                end else if (last) begin
                    busy <= 1'b0;
                end
            end
            if (ce_1m && pending) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tbl_acc_ps <= '0;
            tbl_acc_t  <= '0;
            st_out     <= '0;
            pt_out     <= '0;
            ps_out     <= '0;
            pst_out    <= '0;
        end else begin
            if (issue) begin
                tbl_acc_ps <= sel_ps;
                tbl_acc_t  <= sel_t;
            end
            if (capture) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (slot == SW'(v)) begin
                        st_out[v*OUT_W +: OUT_W]  <= tbl_st_in;
                        pt_out[v*OUT_W +: OUT_W]  <= tbl_pt_in;
                        ps_out[v*OUT_W +: OUT_W]  <= tbl_ps_in;
                        pst_out[v*OUT_W +: OUT_W] <= tbl_pst_in;
                    end
                end
            end
        end
    end

endmodule
